// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: mode encodings and default width.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam int USR_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/usr_bit_slice.sv
// One bit of the universal shift register: 4:1 mode mux feeding a flop with synchronous reset.
module usr_bit_slice
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       shr_src,
    input  logic       shl_src,
    input  logic       load,
    output logic       q
);

    logic d;

    // Any select value that is not a defined mode (including X/Z) falls to hold.
    always_comb begin
        d = q;
        case (mode)
            MODE_HOLD: d = q;
            MODE_SHR:  d = shr_src;
            MODE_SHL:  d = shl_src;
            MODE_LOAD: d = load;
            default:   d = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register (hold / shift right / shift left / parallel load).
// Define USR_SERIAL_OUT_EN to expose so_r/so_l cascade taps.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1,
    input  logic             s0,
    input  logic             sr,
    input  logic             sl,
    input  logic [WIDTH-1:0] pdin,
`ifdef USR_SERIAL_OUT_EN
    output logic             so_r,
    output logic             so_l,
`endif
    output logic [WIDTH-1:0] pdout
);

    logic [1:0]       mode;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;

    assign mode    = {s1, s0};
    // Neighbour vectors: each slice takes its bit of the already-shifted word.
    assign shr_vec = {sr, pdout[WIDTH-1:1]};
    assign shl_vec = {pdout[WIDTH-2:0], sl};

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        usr_bit_slice u_slice (
            .clk     (clk),
            .rst     (rst),
            .mode    (mode),
            .shr_src (shr_vec[i]),
            .shl_src (shl_vec[i]),
            .load    (pdin[i]),
            .q       (pdout[i])
        );
    end

`ifdef USR_SERIAL_OUT_EN
    assign so_r = pdout[0];
    assign so_l = pdout[WIDTH-1];
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=4): directed cases plus randomized
// traffic against an arithmetic reference model.
module tb_universal_shift_reg;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s1 = 1'b0;
    logic         s0 = 1'b0;
    logic         sr = 1'b0;
    logic         sl = 1'b0;
    logic [W-1:0] pdin = '0;
    logic [W-1:0] pdout;
`ifdef USR_SERIAL_OUT_EN
    logic         so_r;
    logic         so_l;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .s1    (s1),
        .s0    (s0),
        .sr    (sr),
        .sl    (sl),
        .pdin  (pdin),
`ifdef USR_SERIAL_OUT_EN
        .so_r  (so_r),
        .so_l  (so_l),
`endif
        .pdout (pdout)
    );

    // Apply one cycle of inputs, then settle 1 time unit past the edge.
    task automatic drive(input logic r, input logic [1:0] m, input logic srv,
                         input logic slv, input logic [W-1:0] p);
        rst  = r;
        s1   = m[1];
        s0   = m[0];
        sr   = srv;
        sl   = slv;
        pdin = p;
        @(posedge clk);
        #1;
    endtask

    // Reference: register value treated as an unsigned integer.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic r,
                                              input logic [1:0] m, input logic srv,
                                              input logic slv, input logic [W-1:0] p);
        int v;
        int full;
        full = 1 << W;
        v = int'(cur);
        if (r) return '0;
        case (m)
            2'd1: v = v / 2 + (srv ? full / 2 : 0);
            2'd2: v = (v * 2 + (slv ? 1 : 0)) % full;
            2'd3: v = int'(p);
            default: v = v;
        endcase
        return W'(v);
    endfunction

    task automatic test_reset();
        drive(1'b1, 2'b11, 1'b1, 1'b1, 4'b1111);
        checks++;
        if (pdout !== 4'b0000) begin
            errors++;
            $display("FAIL reset_load got %b exp 0000", pdout);
        end
        drive(1'b0, 2'b00, 1'b1, 1'b1, 4'b1111);
        checks++;
        if (pdout !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold got %b exp 0000", pdout);
        end
    endtask

    task automatic test_shift_right();
        logic [W-1:0] exp_tab [4] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
        logic         sr_tab  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b01, sr_tab[i], 1'b0, 4'b0110);
            checks++;
            if (pdout !== exp_tab[i]) begin
                errors++;
                $display("FAIL shift_right[%0d] got %b exp %b", i, pdout, exp_tab[i]);
            end
        end
    endtask

    task automatic test_shift_left();
        logic [W-1:0] exp_tab [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0110};
        logic         sl_tab  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        drive(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b10, 1'b1, sl_tab[i], 4'b1001);
            checks++;
            if (pdout !== exp_tab[i]) begin
                errors++;
                $display("FAIL shift_left[%0d] got %b exp %b", i, pdout, exp_tab[i]);
            end
        end
    endtask

    task automatic test_load_hold();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
        drive(1'b0, 2'b11, 1'b0, 1'b0, 4'b1111);
        checks++;
        if (pdout !== 4'b1111) begin
            errors++;
            $display("FAIL load got %b exp 1111", pdout);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 1'b1, 1'b1, 4'b0000);
            checks++;
            if (pdout !== 4'b1111) begin
                errors++;
                $display("FAIL hold[%0d] got %b exp 1111", i, pdout);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
        drive(1'b0, 2'b01, 1'b0, 1'b0, 4'b0000);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 4'b0000);
        drive(1'b0, 2'b01, 1'b0, 1'b0, 4'b0000);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 4'b0000);
        checks++;
        if (pdout !== 4'b1010) begin
            errors++;
            $display("FAIL prio_setup got %b exp 1010", pdout);
        end
        drive(1'b1, 2'b01, 1'b1, 1'b1, 4'b1111);
        checks++;
        if (pdout !== 4'b0000) begin
            errors++;
            $display("FAIL prio_reset got %b exp 0000", pdout);
        end
        drive(1'b0, 2'b01, 1'b1, 1'b0, 4'b0000);
        checks++;
        if (pdout !== 4'b1000) begin
            errors++;
            $display("FAIL prio_restart got %b exp 1000", pdout);
        end
    endtask

`ifdef USR_SERIAL_OUT_EN
    task automatic test_serial_out();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 4'b1001);
        checks++;
        if ({so_l, so_r} !== 2'b11) begin
            errors++;
            $display("FAIL so_after_load got so_l,so_r=%b%b exp 11", so_l, so_r);
        end
        drive(1'b0, 2'b10, 1'b1, 1'b0, 4'b0000);
        checks++;
        if (pdout !== 4'b0010 || {so_l, so_r} !== 2'b00) begin
            errors++;
            $display("FAIL so_after_shl got %b so=%b%b exp 0010 so=00", pdout, so_l, so_r);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] model;
        logic         r;
        logic [1:0]   m;
        logic         srv;
        logic         slv;
        logic [W-1:0] p;
        drive(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
        model = '0;
        for (int i = 0; i < 300; i++) begin
            r   = ($urandom_range(15) == 0);
            m   = 2'($urandom_range(3));
            srv = 1'($urandom_range(1));
            slv = 1'($urandom_range(1));
            p   = W'($urandom);
            drive(r, m, srv, slv, p);
            model = ref_next(model, r, m, srv, slv, p);
            checks++;
            if (pdout !== model) begin
                errors++;
                $display("FAIL random[%0d] mode=%b rst=%b got %b exp %b", i, m, r, pdout, model);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_shift_right();
        test_shift_left();
        test_load_hold();
        test_reset_priority();
`ifdef USR_SERIAL_OUT_EN
        test_serial_out();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
